incr_rr_scheduler: RTL

- Shares one 4-bit ripple incrementer (half-adder chain, carry-in tied 1) between NREQ requesters.
- Each requester owns a 4-bit count register and a sticky overflow flag held inside this block.
- A round-robin arbiter picks one requester per operation. A 2-state FSM sequences operand capture and result write-back.
- Sits between event sources (e.g. per-channel tick counters) and the status/readout logic.

---
 rtl/incr_rr_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/incr_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit ripple incrementer across NREQ counters.
// Optional: define INCR_SATURATE_EN to saturate at 4'hF instead of wrapping.
module incr_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      clr,
    output logic [NREQ-1:0]      gnt,
    output logic [4*NREQ-1:0]    cnt,
    output logic [NREQ-1:0]      ovf,
    output logic                 busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   idx;
    logic [3:0]        opnd;

    logic [3:0]        cnt_q [NREQ];
    logic [NREQ-1:0]   ovf_q;

    logic              win_vld;
    logic [IDXW-1:0]   win_idx;

    logic [4:0]        carry;
    logic [3:0]        sum;
    logic [3:0]        wr_val;

    // Rotating priority: the lowest offset from ptr with a request wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    win_vld = 1'b1;
                    win_idx = IDXW'(i);
                end
            end
        end
    end

    // Half-adder chain with the carry-in tied high.
    assign carry[0] = 1'b1;
    for (genvar b = 0; b < 4; b++) begin : g_ha
        assign sum[b]     = opnd[b] ^ carry[b];
        assign carry[b+1] = opnd[b] & carry[b];
    end

`ifdef INCR_SATURATE_EN
    assign wr_val = carry[4] ? 4'hF : sum;
`else
    assign wr_val = sum;
`endif

    // Sequencer: capture winner and operand in IDLE, write back in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            idx   <= '0;
            opnd  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        idx   <= win_idx;
                        opnd  <= cnt_q[win_idx];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (idx == IDXW'(NREQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= idx + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel counters; a clear wins over a simultaneous write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (clr[i]) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (state == S_EXEC && idx == IDXW'(i)) begin
                    cnt_q[i] <= wr_val;
                    if (carry[4]) begin
                        ovf_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Grant is a decode of the executing index.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (state == S_EXEC) && (idx == IDXW'(i));
        end
    end

    // Flatten the count registers onto the output bus.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[4*i +: 4] = cnt_q[i];
        end
    end

    assign ovf  = ovf_q;
    assign busy = (state == S_EXEC);

endmodule
